// File: rtl/udp_test_pkg.sv
// Shared definitions for the UDP test-pattern generator and checker.
// The pattern alternates {HI,HI} and {LO,LO}, so every word is the complement of the one before it.
package udp_test_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam logic [15:0] PAT_HI = 16'h7FFF;
  localparam logic [15:0] PAT_LO = 16'h8000;

endpackage

// File: rtl/udp_gap_timer.sv
// Counts enabled ticks since the last accepted word and saturates at twice the period.
// Flags an exact-period arrival and fires a single timeout on the tick the count saturates.
module udp_gap_timer #(
  parameter int PERIOD = 21,
  parameter int GW     = $clog2(2*PERIOD+1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ce,
  input  logic i_restart,
  output logic o_eq_period,
  output logic o_timeout_pulse
);

  localparam logic [GW-1:0] G_MAX = GW'(2*PERIOD);
  localparam logic [GW-1:0] G_PER = GW'(PERIOD);

  logic [GW-1:0] r_gap;

  // Restart loads 1 so the value seen at the next accept is the tick distance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_gap <= '0;
    else if (i_ce) begin
      if (i_restart)
        r_gap <= GW'(1);
      else if (r_gap != G_MAX)
        r_gap <= r_gap + GW'(1);
    end
  end

  assign o_eq_period     = (r_gap == G_PER);
  assign o_timeout_pulse = i_ce & ~i_restart & (r_gap == G_MAX - GW'(1));

endmodule

// File: rtl/udp_test_checker.sv
// Receive-side checker for the UDP test-pattern stream: verifies word content and
// spacing, tracks SEARCH/ACQ/LOCKED lock state and keeps saturating statistics.
module udp_test_checker
  import udp_test_pkg::*;
#(
  parameter int IQ_W        = 16,
  parameter int PERIOD      = 21,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [2*IQ_W-1:0] in_dat,
  input  logic              in_valid,
  input  logic              clr,
  output logic              locked,
  output logic [31:0]       word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              data_err,
  output logic              gap_err,
  output logic [2*IQ_W-1:0] last_bad
);

  localparam int DW      = 2*IQ_W;
  localparam int RUN_MAX = (LOCK_CNT > UNLOCK_ERRS) ? LOCK_CNT : UNLOCK_ERRS;
  localparam int RUN_W   = $clog2(RUN_MAX+1);

  chk_state_t        r_state;
  logic [RUN_W-1:0]  r_good_run;
  logic [RUN_W-1:0]  r_bad_run;
  logic [DW-1:0]     r_prev;
  logic              r_have_prev;
  logic [31:0]       r_word_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic              r_data_err;
  logic              r_gap_err;
  logic [DW-1:0]     r_last_bad;

  logic              w_acc;
  logic [IQ_W-1:0]   w_i;
  logic [IQ_W-1:0]   w_q;
  logic              w_pat_ok;
  logic              w_prev_ok;
  logic              w_cgood;
  logic              w_eq_period;
  logic              w_timeout;
  logic              w_tracking;
  logic              w_derr;
  logic              w_gerr;
  logic              w_bad;
  logic              w_good;
  logic              w_cnt_word;

  assign w_acc = clk_en & in_valid;
  assign w_i   = in_dat[DW-1:IQ_W];
  assign w_q   = in_dat[IQ_W-1:0];

  assign w_pat_ok  = (w_i == w_q) && ((w_i == IQ_W'(PAT_HI)) || (w_i == IQ_W'(PAT_LO)));
  assign w_prev_ok = ~r_have_prev | (in_dat == ~r_prev);
  assign w_cgood   = w_pat_ok & w_prev_ok;

  udp_gap_timer #(.PERIOD(PERIOD)) u_gap (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_ce            (clk_en),
    .i_restart       (w_acc),
    .o_eq_period     (w_eq_period),
    .o_timeout_pulse (w_timeout)
  );

  // Content and spacing verdicts only matter once the checker has a reference word.
  assign w_tracking = (r_state != SEARCH);
  assign w_derr     = w_tracking & w_acc & ~w_cgood;
  assign w_gerr     = w_tracking & ((w_acc & ~w_eq_period) | w_timeout);
  assign w_bad      = w_derr | w_gerr;
  assign w_good     = w_tracking & w_acc & ~w_bad;
  assign w_cnt_word = w_tracking & w_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEARCH;
      r_good_run <= '0;
      r_bad_run  <= '0;
    end else begin
      case (r_state)
        SEARCH: begin
          if (w_acc & w_cgood) begin
            r_state    <= ACQ;
            r_good_run <= RUN_W'(1);
            r_bad_run  <= '0;
          end
        end
        ACQ: begin
          if (w_bad) begin
            r_state    <= SEARCH;
            r_good_run <= '0;
          end else if (w_good) begin
            r_good_run <= r_good_run + RUN_W'(1);
            if (r_good_run == RUN_W'(LOCK_CNT-1)) begin
              r_state   <= LOCKED;
              r_bad_run <= '0;
            end
          end
        end
        LOCKED: begin
          if (w_bad) begin
            if (r_bad_run == RUN_W'(UNLOCK_ERRS-1)) begin
              r_state    <= SEARCH;
              r_good_run <= '0;
              r_bad_run  <= '0;
            end else
              r_bad_run <= r_bad_run + RUN_W'(1);
          end else if (w_good)
            r_bad_run <= '0;
        end
        default: begin
          r_state    <= SEARCH;
          r_good_run <= '0;
          r_bad_run  <= '0;
        end
      endcase
    end
  end

  // Every accepted word becomes the reference, so one corrupt word never snowballs into a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_have_prev <= 1'b0;
    end else if (w_acc) begin
      r_prev      <= in_dat;
      r_have_prev <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_err <= 1'b0;
      r_gap_err  <= 1'b0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
      r_last_bad <= '0;
    end else begin
      r_data_err <= w_derr;
      r_gap_err  <= w_gerr;

      if (clr)
        r_word_cnt <= {31'd0, w_cnt_word};
      else if (w_cnt_word && (r_word_cnt != '1))
        r_word_cnt <= r_word_cnt + 32'd1;

      if (clr)
        r_err_cnt <= {{(CNT_W-1){1'b0}}, w_bad};
      else if (w_bad && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNT_W'(1);

      if (w_derr)
        r_last_bad <= in_dat;
      else if (clr)
        r_last_bad <= '0;
    end
  end

  assign locked   = (r_state == LOCKED);
  assign word_cnt = r_word_cnt;
  assign err_cnt  = r_err_cnt;
  assign data_err = r_data_err;
  assign gap_err  = r_gap_err;
  assign last_bad = r_last_bad;

endmodule

// File: tb/tb_udp_test_checker.sv
// Randomized scoreboard bench for udp_test_checker: a cycle-level reference model
// predicts all outputs after each clock; a monitor compares them one clock later.
module tb_udp_test_checker;

  localparam int PERIOD = 21;
  localparam int LOCKN  = 4;
  localparam int UNLK   = 3;
  localparam int CNT_W  = 4;
  localparam int EC_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              clk_en;
  logic [31:0]       in_dat;
  logic              in_valid;
  logic              clr;
  logic              locked;
  logic [31:0]       word_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic              data_err;
  logic              gap_err;
  logic [31:0]       last_bad;

  udp_test_checker #(
    .IQ_W(16), .PERIOD(PERIOD), .LOCK_CNT(LOCKN), .UNLOCK_ERRS(UNLK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_dat(in_dat), .in_valid(in_valid),
    .clr(clr), .locked(locked), .word_cnt(word_cnt), .err_cnt(err_cnt),
    .data_err(data_err), .gap_err(gap_err), .last_bad(last_bad)
  );

  typedef struct packed {
    logic             lk;
    logic [31:0]      wc;
    logic [CNT_W-1:0] ec;
    logic             de;
    logic             ge;
    logic [31:0]      lb;
  } snap_t;

  snap_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  // Reference model: mode 0 searching, 1 acquiring, 2 locked
  int          m_mode, m_gap, m_good, m_bad, m_ec;
  logic [31:0] m_prev, m_wc, m_lb;
  bit          m_seen;
  logic [31:0] pat = 32'h7FFF7FFF;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycles=%0d required end before limit", cyc);
    $fatal(1);
  end

  task automatic model_reset();
    m_mode = 0; m_gap = 0; m_good = 0; m_bad = 0; m_ec = 0;
    m_prev = 0; m_wc = 0; m_lb = 0; m_seen = 0;
  endtask

  task automatic step(input bit ce, input bit v, input logic [31:0] d, input bit c, input bit rst);
    snap_t e;
    bit acc, cg, de, ge, cnted, badev;
    @(negedge clk);
    clk_en = ce; in_valid = v; in_dat = d; clr = c; rst_n = rst;
    de = 0; ge = 0; cnted = 0; badev = 0;
    if (!rst) model_reset();
    else begin
      acc = ce && v;
      if (acc) begin
        cg = (d[31:16] == d[15:0]) && (d[31:16] == 16'h7FFF || d[31:16] == 16'h8000)
             && (!m_seen || d == ~m_prev);
        if (m_mode == 0) begin
          if (cg) begin m_mode = 1; m_good = 1; m_bad = 0; end
        end else begin
          cnted = 1;
          de = !cg;
          ge = (m_gap != PERIOD);
          badev = de || ge;
          if (!badev) begin
            if (m_mode == 1) begin
              m_good++;
              if (m_good == LOCKN) begin m_mode = 2; m_bad = 0; end
            end else m_bad = 0;
          end
        end
        m_prev = d; m_seen = 1; m_gap = 1;
      end else if (ce && m_gap < 2*PERIOD) begin
        m_gap++;
        if (m_gap == 2*PERIOD && m_mode != 0) begin ge = 1; badev = 1; end
      end
      if (badev) begin
        if (m_mode == 1) begin m_mode = 0; m_good = 0; end
        else if (m_mode == 2) begin
          m_bad++;
          if (m_bad == UNLK) begin m_mode = 0; m_good = 0; m_bad = 0; end
        end
      end
      if (c) m_wc = {31'd0, cnted};
      else if (cnted && m_wc != 32'hFFFF_FFFF) m_wc = m_wc + 1;
      if (c) m_ec = badev ? 1 : 0;
      else if (badev && m_ec < EC_MAX) m_ec++;
      if (de) m_lb = d;
      else if (c) m_lb = 0;
    end
    e.lk = (m_mode == 2); e.wc = m_wc; e.ec = CNT_W'(m_ec);
    e.de = de; e.ge = ge; e.lb = m_lb;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    snap_t g, e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      g.lk = locked; g.wc = word_cnt; g.ec = err_cnt;
      g.de = data_err; g.ge = gap_err; g.lb = last_bad;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d got lk=%0b wc=%0d ec=%0d de=%0b ge=%0b lb=%h required lk=%0b wc=%0d ec=%0d de=%0b ge=%0b lb=%h",
                 cyc, g.lk, g.wc, g.ec, g.de, g.ge, g.lb, e.lk, e.wc, e.ec, e.de, e.ge, e.lb);
      end
    end
  end

  function automatic bit pick_ce(input int div, input int n);
    if (div == 0) return bit'($urandom_range(0, 1));
    return (n % div) == 0;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 1, $urandom, 0, 0);
  endtask

  // nwords pattern words at PERIOD enabled ticks; word bad_k is corrupted, word skew_k
  // arrives skew ticks off, word clr_k's accept carries clr, then tail idle cycles.
  task automatic run(input int nwords, input int div, input int bad_k, input int skew_k,
                     input int skew, input int clr_k, input int tail, input int clr_rate);
    int  n = 0;
    bit  ce, rc, done;
    int  sp, t;
    logic [31:0] d;
    for (int k = 0; k < nwords; k++) begin
      sp = (k == skew_k) ? PERIOD + skew : PERIOD;
      t = 0; done = 0;
      while (!done) begin
        ce = pick_ce(div, n); n++;
        rc = (clr_rate > 0) && ($urandom_range(0, clr_rate - 1) == 0);
        if (ce) t++;
        if (ce && t == sp) begin
          d = (k == bad_k) ? 32'h7FFF0000 : pat;
          pat = ~pat;
          step(1, 1, d, rc || (k == clr_k), 1);
          done = 1;
        end else
          step(ce, !ce && $urandom_range(0, 1) == 1, $urandom, rc, 1);
      end
    end
    for (int i = 0; i < tail; i++) begin
      ce = pick_ce(div, n); n++;
      step(ce, 0, $urandom, (clr_rate > 0) && ($urandom_range(0, clr_rate - 1) == 0), 1);
    end
  endtask

  initial begin
    int sk;
    rst_n = 0; clk_en = 0; in_valid = 0; in_dat = 0; clr = 0;
    model_reset();
    do_reset(3);
    run(10, 1, -1, -1, 0, -1, 0, 0);
    run(8, 1, 5, -1, 0, -1, 0, 0);
    run(8, 1, -1, 3, -1, -1, 0, 0);
    run(3, 1, -1, -1, 0, -1, 60, 0);
    run(1, 1, -1, -1, 0, -1, 60, 0);
    run(1, 1, -1, -1, 0, -1, 60, 0);
    do_reset(2);
    run(10, 3, -1, -1, 0, -1, 0, 0);
    run(6, 3, 2, -1, 0, 2, 0, 0);
    run(10, 1, -1, -1, 0, -1, 0, 0);
    do_reset(4);
    run(6, 1, -1, -1, 0, -1, 10, 0);
    for (int r = 0; r < 40; r++) begin
      sk = $urandom_range(0, 1) ? 1 : -1;
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
      run($urandom_range(3, 12), $urandom_range(0, 3),
          $urandom_range(0, 2) == 0 ? $urandom_range(0, 11) : -1,
          $urandom_range(0, 2) == 0 ? $urandom_range(0, 11) : -1, sk, -1,
          $urandom_range(0, 3) == 0 ? $urandom_range(0, 100) : 0, 400);
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
